// File: rtl/stack_reverser_pkg.sv
// Shared definitions for the stack reverser: the command codes driven on
// stk_cmd and the controller state encoding.
package stack_reverser_pkg;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_CLR  = 2'b01;
  localparam logic [1:0] CMD_PUSH = 2'b10;
  localparam logic [1:0] CMD_POP  = 2'b11;

  typedef enum logic [3:0] {
    ST_CLR    = 4'd0,
    ST_CLR_W  = 4'd1,
    ST_IDLE   = 4'd2,
    ST_PUSH   = 4'd3,
    ST_PUSH_W = 4'd4,
    ST_POP    = 4'd5,
    ST_POP_W  = 4'd6,
    ST_OUT    = 4'd7,
    ST_ERR    = 4'd8
  } state_t;

endpackage

// File: rtl/stack_reverser.sv
// Byte-stream reverser driving an external LIFO stack.
// Bytes from the upstream interface are pushed one at a time; at the end of
// a frame (or when the stack fills) the stack is popped and the bytes are
// replayed downstream in reverse order, out_last marking the final byte.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_data/in_valid/in_last/in_ready     upstream byte interface
//   out_data/out_valid/out_last/out_ready downstream byte interface
//   stk_cmd/stk_wdata               stack command (nop/clr/push/pop) and push data
//   stk_rdata                       stack pop data
//   stk_full/stk_empty/stk_error    stack flags
//   busy                            controller not in IDLE
//   ovf                             sticky: a frame was split on a full stack
//   err                             sticky: the stack reported an error
module stack_reverser
  import stack_reverser_pkg::*;
#(
  parameter int unsigned CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic [1:0] stk_cmd,
  output logic [7:0] stk_wdata,
  input  logic [7:0] stk_rdata,
  input  logic       stk_full,
  input  logic       stk_empty,
  input  logic       stk_error,
  output logic       busy,
  output logic       ovf,
  output logic       err
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_q, last_d;

  logic [1:0]       cmd_d;
  logic [7:0]       wdata_d, out_data_d;
  logic             out_valid_d, out_last_d, in_ready_d, ovf_d, err_d;

  logic [CNT_W-1:0] cnt_inc, cnt_dec;

  assign cnt_inc = count_q + 1'b1;
  assign cnt_dec = count_q - 1'b1;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    last_d      = last_q;
    cmd_d       = CMD_NOP;
    wdata_d     = stk_wdata;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    in_ready_d  = 1'b0;
    ovf_d       = ovf;
    err_d       = err;

    unique case (state_q)
      // Reset leaves stk_cmd at nop, so CLR first raises the clear for one
      // cycle and only then moves on.
      ST_CLR: begin
        if (stk_cmd == CMD_CLR) begin
          state_d = ST_CLR_W;
        end else begin
          cmd_d = CMD_CLR;
        end
      end
      ST_CLR_W: begin
        state_d    = ST_IDLE;
        in_ready_d = 1'b1;
      end
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready) begin
          state_d    = ST_PUSH;
          cmd_d      = CMD_PUSH;
          wdata_d    = in_data;
          last_d     = in_last;
          in_ready_d = 1'b0;
        end
      end
      ST_PUSH: begin
        state_d = ST_PUSH_W;
      end
      ST_PUSH_W: begin
        // A stack that still reads empty after a push has lost the byte.
        if (stk_error || stk_empty) begin
          state_d     = ST_ERR;
          cmd_d       = CMD_CLR;
          err_d       = 1'b1;
          count_d     = '0;
        end else begin
          count_d = cnt_inc;
          if (last_q) begin
            state_d = ST_POP;
            cmd_d   = CMD_POP;
          end else if (stk_full || (cnt_inc == '1)) begin
            state_d = ST_POP;
            cmd_d   = CMD_POP;
            ovf_d   = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            in_ready_d = 1'b1;
          end
        end
      end
      ST_POP: begin
        state_d = ST_POP_W;
      end
      ST_POP_W: begin
        if (stk_error) begin
          state_d     = ST_ERR;
          cmd_d       = CMD_CLR;
          err_d       = 1'b1;
          count_d     = '0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else begin
          state_d     = ST_OUT;
          out_data_d  = stk_rdata;
          count_d     = cnt_dec;
          out_valid_d = 1'b1;
          out_last_d  = (cnt_dec == '0);
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (count_q == '0) begin
            state_d    = ST_IDLE;
            in_ready_d = 1'b1;
          end else begin
            state_d = ST_POP;
            cmd_d   = CMD_POP;
          end
        end
      end
      ST_ERR: begin
        state_d = ST_CLR_W;
      end
      default: begin
        state_d = ST_CLR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLR;
      count_q   <= '0;
      last_q    <= 1'b0;
      stk_cmd   <= CMD_NOP;
      stk_wdata <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      in_ready  <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      last_q    <= last_d;
      stk_cmd   <= cmd_d;
      stk_wdata <= wdata_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      in_ready  <= in_ready_d;
      ovf       <= ovf_d;
      err       <= err_d;
      busy      <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_stack_reverser.sv
module tb_stack_reverser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic [1:0] stk_cmd;
  logic [7:0] stk_wdata;
  logic [7:0] stk_rdata = 8'h00;
  logic       stk_full  = 1'b0;
  logic       stk_empty = 1'b1;
  logic       stk_error = 1'b0;
  logic       busy;
  logic       ovf;
  logic       err;

  int unsigned tests = 0;
  int unsigned fails = 0;

  stack_reverser #(.CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .stk_cmd   (stk_cmd),
    .stk_wdata (stk_wdata),
    .stk_rdata (stk_rdata),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .stk_error (stk_error),
    .busy      (busy),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  // External stack model, depth 8: commands act on posedge, flags on negedge.
  logic [7:0]  mem [8];
  int unsigned sp = 0;
  logic        serr = 1'b0;
  logic        force_err = 1'b0;

  always @(posedge clk) begin
    case (stk_cmd)
      2'b01: begin
        sp   <= 0;
        serr <= 1'b0;
      end
      2'b10: begin
        if (sp < 8) begin
          mem[sp] <= stk_wdata;
          sp      <= sp + 1;
        end else begin
          serr <= 1'b1;
        end
      end
      2'b11: begin
        if (sp > 0) begin
          stk_rdata <= mem[sp-1];
          sp        <= sp - 1;
        end else begin
          serr <= 1'b1;
        end
      end
      default: ;
    endcase
  end

  always @(negedge clk) begin
    stk_full  <= (sp == 8);
    stk_empty <= (sp == 0);
    stk_error <= serr | force_err;
  end

  // Observation of stack commands and downstream handshakes.
  logic [7:0]  push_q [$];
  logic [7:0]  out_q  [$];
  logic        last_q [$];
  int unsigned clr_cnt = 0;
  int unsigned pop_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stk_cmd == 2'b10) push_q.push_back(stk_wdata);
      if (stk_cmd == 2'b01) clr_cnt++;
      if (stk_cmd == 2'b11) pop_cnt++;
      if (out_valid && out_ready) begin
        out_q.push_back(out_data);
        last_q.push_back(out_last);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(tag, 32'd0, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] first, input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      send_byte(first + 8'(i), (i == n - 1));
  endtask

  task automatic wait_out(input string tag, input int unsigned n);
    for (int i = 0; i < 1000; i++) begin
      if (out_q.size() >= n) break;
      @(negedge clk);
    end
    check(tag, out_q.size(), n);
  endtask

  task automatic clear_obs();
    push_q.delete();
    out_q.delete();
    last_q.delete();
  endtask

  logic [7:0] exp41 [12] = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03,
                             8'h02, 8'h01, 8'h0C, 8'h0B, 8'h0A, 8'h09};
  logic [7:0] exp39 [3]  = '{8'h03, 8'h02, 8'h01};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    bit seen;
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_stk_cmd",   stk_cmd,   2'b00);
    check("rst_stk_wdata", stk_wdata, 8'h00);
    check("rst_out_data",  out_data,  8'h00);
    check("rst_in_ready",  in_ready,  1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last",  out_last,  1'b0);
    check("rst_ovf",       ovf,       1'b0);
    check("rst_err",       err,       1'b0);
    check("rst_busy",      busy,      1'b1);

    // Reset release: a single clear pulse, then IDLE
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stk_cmd == 2'b01) begin
        seen = 1'b1;
        break;
      end
    end
    check("clr_seen", seen, 1'b1);
    @(negedge clk);
    check("clr_one_cycle", stk_cmd, 2'b00);
    wait_idle("idle_after_reset");
    check("clr_count", clr_cnt, 1);
    check("idle_busy", busy, 1'b0);
    check("idle_cmd",  stk_cmd, 2'b00);

    // Three-byte frame
    clear_obs();
    send_frame(8'h01, 3);
    wait_out("f3_count", 3);
    check("f3_pushes", push_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("f3_push%0d", i), push_q[i], 8'(i + 1));
      check($sformatf("f3_out%0d", i), out_q[i], exp39[i]);
      check($sformatf("f3_last%0d", i), last_q[i], (i == 2));
    end
    check("f3_ovf", ovf, 1'b0);
    check("f3_err", err, 1'b0);
    wait_idle("f3_idle");

    // Single-byte frame
    clear_obs();
    c0 = pop_cnt;
    send_frame(8'hAA, 1);
    wait_out("f1_count", 1);
    check("f1_pushes", push_q.size(), 1);
    check("f1_push",   push_q[0], 8'hAA);
    check("f1_pops",   pop_cnt - c0, 1);
    check("f1_out",    out_q[0], 8'hAA);
    check("f1_last",   last_q[0], 1'b1);
    wait_idle("f1_idle");

    // Twelve bytes into a depth-8 stack: split after 08
    clear_obs();
    send_frame(8'h01, 12);
    wait_out("f12_count", 12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("f12_push%0d", i), push_q[i], 8'(i + 1));
      check($sformatf("f12_out%0d", i), out_q[i], exp41[i]);
      check($sformatf("f12_last%0d", i), last_q[i], (i == 7 || i == 11));
    end
    check("f12_ovf", ovf, 1'b1);
    check("f12_err", err, 1'b0);
    wait_idle("f12_idle");

    // Downstream stall in OUT
    clear_obs();
    out_ready = 1'b0;
    send_frame(8'h21, 2);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("stall_valid_seen", seen, 1'b1);
    c0 = pop_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_data%0d", i), out_data, 8'h22);
      check($sformatf("stall_valid%0d", i), out_valid, 1'b1);
    end
    check("stall_no_pop", pop_cnt - c0, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_out("stall_count", 2);
    check("stall_out0", out_q[0], 8'h22);
    check("stall_out1", out_q[1], 8'h21);
    check("stall_last1", last_q[1], 1'b1);
    wait_idle("stall_idle");

    // Stack error during POP_W
    clear_obs();
    c0 = clr_cnt;
    send_frame(8'h55, 2);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (stk_cmd == 2'b11) begin
        seen = 1'b1;
        break;
      end
    end
    check("errt_pop_seen", seen, 1'b1);
    @(posedge clk);
    #1;
    force_err = 1'b1;
    @(posedge clk);
    #1;
    force_err = 1'b0;
    check("errt_clr_cmd", stk_cmd, 2'b01);
    check("errt_err", err, 1'b1);
    check("errt_no_valid", out_valid, 1'b0);
    wait_idle("errt_idle");
    check("errt_clr_count", clr_cnt - c0, 1);
    check("errt_discard", out_q.size(), 0);
    check("errt_busy", busy, 1'b0);

    // Count restarted at zero: a single byte comes straight back as last
    clear_obs();
    send_frame(8'h77, 1);
    wait_out("post_err_count", 1);
    check("post_err_out", out_q[0], 8'h77);
    check("post_err_last", last_q[0], 1'b1);
    check("post_err_sticky", err, 1'b1);
    check("post_ovf_sticky", ovf, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
